// File: rtl/seq_mult4_pkg.sv
// Shared types and constants for the seq_mult4 shift-add multiplier.
package seq_mult4_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter must hold 0..width-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/mult_add_unit.sv
// Combinational accumulate step: acc + mcand when the current multiplier bit is set.
module mult_add_unit #(
    parameter int unsigned W2 = 8
) (
    input  logic [W2-1:0] acc_i,
    input  logic [W2-1:0] mcand_i,
    input  logic          add_en_i,
    output logic [W2-1:0] sum_o
);

    always_comb begin
        sum_o = add_en_i ? (acc_i + mcand_i) : acc_i;
    end

endmodule

// File: rtl/seq_mult4.sv
// Sequential shift-add unsigned multiplier, one multiplier bit per clock.
// Define SEQ_MULT4_EARLY_TERM_EN to finish as soon as no set multiplier bits remain.
module seq_mult4
    import seq_mult4_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned    CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [2*WIDTH-1:0]   sum;
    logic                 last;

    mult_add_unit #(
        .W2(2*WIDTH)
    ) u_add (
        .acc_i    (acc_q),
        .mcand_i  (mcand_q),
        .add_en_i (mplier_q[0]),
        .sum_o    (sum)
    );

`ifdef SEQ_MULT4_EARLY_TERM_EN
    assign last = (cnt_q == CNT_LAST) || (mplier_q[WIDTH-1:1] == '0);
`else
    assign last = (cnt_q == CNT_LAST);
`endif

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (last) begin
                    product_d = sum;
                    state_d   = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Flags are registered copies of the next state so outputs come straight from flops.
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: doc/seq_mult4.md
# seq_mult4

Sequential shift-add multiplier that computes the unsigned product of two WIDTH-bit operands, one multiplier bit per clock. It sits in the processor's execute path next to the combinational adder datapath. It accepts operands on a single-cycle start strobe and returns a 2·WIDTH-bit product with a one-cycle done pulse. The product stays held for the writeback stage until the next operation completes.

## Interface
Parameters:
- WIDTH, 4, operand width in bits (≥2); product is 2·WIDTH bits.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  operation request; sampled only in IDLE.
- a  in  WIDTH  multiplicand; captured on the accepted start edge.
- b  in  WIDTH  multiplier; captured on the accepted start edge.
- busy  out  1  high while in RUN.
- done  out  1  high for exactly one cycle, in DONE.
- product  out  2·WIDTH  last completed result; held until the next completion.

## Operation
- States are IDLE, RUN and DONE.
- Internal registers:
  - mcand (2·WIDTH): zero-extended a.
  - mplier (WIDTH): b.
  - acc (2·WIDTH).
  - cnt (ceil(log2 WIDTH) bits).
- IDLE:
  - If start=1 at an edge: load mcand={0,a}, mplier=b, acc=0, cnt=0, and go to RUN.
  - If start=0: stay in IDLE.
- RUN, each edge:
  - If mplier[0] is set, acc ← acc + mcand (2·WIDTH-bit add; the sum cannot overflow).
  - mcand ← mcand<<1, mplier ← mplier>>1, cnt ← cnt+1.
  - If cnt==WIDTH−1 (terminal condition), go to DONE and load product with the final acc value (including this edge's add).
- DONE: one cycle only, then unconditionally back to IDLE.
- start is ignored in RUN and DONE, with no queuing. Operands can change freely after the accept edge.
- Reset (asserted at any time, including mid-RUN):
  - state=IDLE.
  - busy=0, done=0, product=0.
  - All internal registers are cleared.
  - Any in-flight operation is discarded.
- Arithmetic is unsigned. The full 2·WIDTH-bit product is always exact.

## Timing
- Accept edge N = the edge at which start=1 is sampled in IDLE.
- busy is high from after edge N until the completion edge.
- Without early termination:
  - Completion edge is N+WIDTH.
  - done=1 in the cycle between N+WIDTH and N+WIDTH+1.
  - product is valid from edge N+WIDTH.
- The earliest next accept edge is N+WIDTH+2. A start held high through DONE is accepted at that edge.
- busy and done are never high together. done is never high for two consecutive cycles.
- All outputs are registered, with no combinational path from input to output.

## Configuration
- Macro: SEQ_MULT4_EARLY_TERM_EN.
- Defined: the terminal condition becomes (cnt==WIDTH−1) OR (mplier>>1 == 0). The operation completes once no set multiplier bits remain.
  - Latency becomes max(1, index of highest set bit of b + 1) edges.
  - b=0 completes at N+1 with product 0.
- Undefined: latency is always WIDTH edges, independent of the data.
- The product value is identical in both builds. Only the latency differs.

## Structure
- Shared package:
  - State enum (IDLE, RUN, DONE).
  - Default WIDTH constant.
  - A function for the cnt width.
- One sub-module, mult_add_unit: a 2·WIDTH-bit combinational adder computing acc+mcand, gated by mplier[0].
- The sequencer, shift registers and product register stay in seq_mult4.

## Test plan
- a=15, b=15, start at edge N → done at N+4 (WIDTH=4, no macro), product=225, busy high for exactly 4 cycles.
- a=3, b=5 → product=15. Then a=9, b=0 → product=0.
  - With the macro, done comes at N+1.
  - Without the macro, done comes at N+4.
- With the macro, a=7, b=4'b0010 → done at N+2, product=14. Then b=4'b1000 → done at N+4, product=56.
- start pulsed with a=1, b=1 during RUN of a 6×7 operation → ignored. The result is 42, with exactly one done pulse.
- rst asserted asynchronously mid-RUN (between clock edges) → busy, done and product go to 0 immediately. No done follows. The next start (a=2, b=3) yields 6 with normal latency.
- start held high continuously → accepts at N, N+6, N+12 (no macro). product updates only at each completion edge, with exactly one done per operation.
